// File: rtl/spike_round_scheduler_pkg.sv
// Shared definitions for the spike round scheduler: spike codes, FSM states,
// and the {spike, id} broadcast packing also used by the neuron's spike_in.
package spike_round_scheduler_pkg;

  localparam int TEN_W   = 2;
  localparam int NID_W   = 9;
  localparam int BCAST_W = TEN_W + NID_W;

  localparam logic [TEN_W-1:0] SPK_NONE = 2'd0;
  localparam logic [TEN_W-1:0] SPK_POS  = 2'd1;
  localparam logic [TEN_W-1:0] SPK_NEG  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_SCAN,
    S_BCAST
  } state_e;

endpackage

// File: rtl/spike_round_scheduler_rr_scan_ptr.sv
// Round-robin scan pointer: wrapping probe pointer, probe counter and the
// origin of the next scan (one past the last winner).
module rr_scan_ptr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         init,
  input  logic         load,
  input  logic         step,
  input  logic         hit,
  input  logic [W-1:0] active,
  output logic [W-1:0] ptr,
  output logic         last
);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] origin_q, origin_d;
  logic [W-1:0] ptr_inc;

  assign ptr_inc = (ptr_q == active - W'(1)) ? '0 : ptr_q + W'(1);

  // The last winner is kept as (winner+1) mod active, i.e. where the next
  // scan begins; a reset or init value of 0 is the "active-1" equivalent.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    origin_d = origin_q;
    if (init)     origin_d = '0;
    else if (hit) origin_d = ptr_inc;
    if (load) begin
      ptr_d = origin_q;
      cnt_d = '0;
    end else if (step) begin
      ptr_d = ptr_inc;
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      origin_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      origin_q <= origin_d;
    end
  end

  assign ptr  = ptr_q;
  assign last = (cnt_q == active - W'(1));

endmodule

// File: rtl/spike_round_scheduler.sv
// Sequences annealing iterations: wait for the network, round-robin pick one
// spike, broadcast it with networkDone, repeat num_iter times.
module spike_round_scheduler
  import spike_round_scheduler_pkg::*;
#(
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = NID_W,
  parameter int TEN_DATA_WIDTH  = TEN_W,
  parameter int ITER_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                reset_l,
  input  logic                                start,
  input  logic [NEURON_ID_WIDTH-1:0]          active_neuron,
  input  logic [ITER_WIDTH-1:0]               num_iter,
  input  logic                                all_en_network,
  input  logic [TEN_DATA_WIDTH-1:0]           rd_spike,
  output logic [NEURON_ID_WIDTH-1:0]          rd_id,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bcast,
  output logic                                en_spike,
  output logic                                networkDone,
  output logic                                busy,
  output logic                                run_done,
  output logic [ITER_WIDTH-1:0]               iter_count
);

  localparam int BW = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

  state_e                     state_q, state_d;
  logic [NEURON_ID_WIDTH-1:0] active_q, active_d;
  logic [ITER_WIDTH-1:0]      num_iter_q, num_iter_d;
  logic [ITER_WIDTH-1:0]      iter_count_q, iter_count_d;
  logic [BW-1:0]              spike_bcast_q, spike_bcast_d;
  logic en_spike_q, en_spike_d;
  logic network_done_q, network_done_d;
  logic busy_q, busy_d;
  logic run_done_q, run_done_d;

  logic                       sp_init, sp_load, sp_step, sp_hit, sp_last;
  logic [NEURON_ID_WIDTH-1:0] ptr;
  logic                       probe_hit;

  // Code 3 is illegal and counts as no spike.
  assign probe_hit = (rd_spike == TEN_DATA_WIDTH'(SPK_POS)) ||
                     (rd_spike == TEN_DATA_WIDTH'(SPK_NEG));

  rr_scan_ptr #(.W(NEURON_ID_WIDTH)) u_scan (
    .clk    (clk),
    .reset_l(reset_l),
    .init   (sp_init),
    .load   (sp_load),
    .step   (sp_step),
    .hit    (sp_hit),
    .active (active_q),
    .ptr    (ptr),
    .last   (sp_last)
  );

  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    num_iter_d     = num_iter_q;
    iter_count_d   = iter_count_q;
    spike_bcast_d  = spike_bcast_q;
    en_spike_d     = 1'b0;
    network_done_d = 1'b0;
    busy_d         = busy_q;
    run_done_d     = 1'b0;
    sp_init        = 1'b0;
    sp_load        = 1'b0;
    sp_step        = 1'b0;
    sp_hit         = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        active_d     = active_neuron;
        num_iter_d   = num_iter;
        iter_count_d = '0;
        sp_init      = 1'b1;
        if (num_iter == '0 || active_neuron == '0) begin
          run_done_d = 1'b1;
        end else begin
          state_d    = S_KICK;
          en_spike_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (all_en_network) begin
        sp_load = 1'b1;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        // Winner is registered on the way into BCAST so it is stable both in
        // the networkDone cycle and the cycle after, when neurons sample it.
        if (probe_hit) begin
          spike_bcast_d  = {rd_spike, ptr};
          sp_hit         = 1'b1;
          network_done_d = 1'b1;
          state_d        = S_BCAST;
        end else if (sp_last) begin
          spike_bcast_d  = '0;
          network_done_d = 1'b1;
          state_d        = S_BCAST;
        end else begin
          sp_step = 1'b1;
        end
      end
      S_BCAST: begin
        iter_count_d = (iter_count_q == '1) ? iter_count_q
                                             : iter_count_q + ITER_WIDTH'(1);
        if (iter_count_d == num_iter_q) begin
          run_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q        <= S_IDLE;
      active_q       <= '0;
      num_iter_q     <= '0;
      iter_count_q   <= '0;
      spike_bcast_q  <= '0;
      en_spike_q     <= 1'b0;
      network_done_q <= 1'b0;
      busy_q         <= 1'b0;
      run_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      num_iter_q     <= num_iter_d;
      iter_count_q   <= iter_count_d;
      spike_bcast_q  <= spike_bcast_d;
      en_spike_q     <= en_spike_d;
      network_done_q <= network_done_d;
      busy_q         <= busy_d;
      run_done_q     <= run_done_d;
    end
  end

  assign rd_id       = ptr;
  assign spike_bcast = spike_bcast_q;
  assign en_spike    = en_spike_q;
  assign networkDone = network_done_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign iter_count  = iter_count_q;

endmodule

// File: doc/spike_round_scheduler.md
# spike_round_scheduler

Sequences the annealing loop of the neuron array for a run of a programmed number of iterations. Each iteration it:
- waits until every neuron has emitted (requests the network),
- scans the neurons' spike outputs round-robin from one past the previous winner,
- broadcasts exactly one winning spike to all neurons,
- pulses `networkDone` so the neurons take the spike and update Vmem/spin.

It sits at the top level between the host control registers and the neuron array. It replaces ad-hoc sequencing of `en_spike` and `networkDone`.

## Interface
Parameters:
- `NUM_NEURON`, 512: physical neuron count.
- `NEURON_ID_WIDTH`, 9: neuron index width.
- `TEN_DATA_WIDTH`, 2: spike code width (0 none, 1 positive, 2 negative, 3 illegal).
- `ITER_WIDTH`, 16: iteration counter width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_l`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle run request; sampled only in IDLE.
- `active_neuron`  in  NEURON_ID_WIDTH  neurons in use (IDs 0..active_neuron-1); sampled at start.
- `num_iter`  in  ITER_WIDTH  iterations per run; sampled at start.
- `all_en_network`  in  1  AND of all active neurons' `en_network`.
- `rd_spike`  in  TEN_DATA_WIDTH  spike of neuron `rd_id`, combinational, same cycle.
- `rd_id`  out  NEURON_ID_WIDTH  scan pointer to the spike read mux.
- `spike_bcast`  out  TEN_DATA_WIDTH+NEURON_ID_WIDTH  {spike, id} to every neuron's `spike_in`; registered.
- `en_spike`  out  1  one-cycle kick to the neurons at run start.
- `networkDone`  out  1  one-cycle broadcast-valid pulse.
- `busy`  out  1  high from the cycle after an accepted start until run_done.
- `run_done`  out  1  one-cycle pulse at run end.
- `iter_count`  out  ITER_WIDTH  completed iterations in the current or last run.

## Operation
States: IDLE, KICK, WAIT, SCAN, BCAST.

- **Reset** (async, any state): state IDLE; `rd_id`=0; `spike_bcast`=0; `en_spike`=0; `networkDone`=0; `busy`=0; `run_done`=0; `iter_count`=0; last winner register = active-1 equivalent, so the first scan starts at ID 0.
- **IDLE**: `start`=1 latches `active_neuron`/`num_iter`, clears `iter_count` and sets the scan origin to 0.
  - If latched num_iter==0 or active_neuron==0: pulse `run_done` next cycle, stay IDLE, no `en_spike`.
  - Otherwise go to KICK.
- **KICK**: `en_spike`=1 for this single cycle; `busy`=1; go to WAIT.
- **WAIT**: hold until `all_en_network`=1, then go to SCAN with ptr = (last_winner+1) mod active and scan count = 0.
- **SCAN**: `rd_id`=ptr.
  - If `rd_spike` is 1 or 2: record winner = {rd_spike, ptr} and last_winner = ptr; go to BCAST.
  - Otherwise: ptr = ptr+1, wrapping to 0 at active_neuron; count++.
  - If count == active-1 with no hit: winner = {0, 0}; last_winner unchanged; go to BCAST.
  - `rd_spike`=3 is treated as no spike.
- **BCAST**: load `spike_bcast` with the winner; `networkDone`=1 this cycle; iter_count++.
  - If the new iter_count == num_iter: pulse `run_done` next cycle, drop `busy`, go to IDLE.
  - Else go to WAIT.
- `spike_bcast` holds its value until the next BCAST. Neurons sample it in the cycle after `networkDone`, so it must be stable then.
- `start` while busy is ignored. `all_en_network` outside WAIT is ignored.
- `iter_count` saturates at 2^ITER_WIDTH-1; it cannot exceed num_iter.

## Timing
- start (IDLE) → KICK next edge → `en_spike` high 1 cycle.
- WAIT exit occurs on the edge after `all_en_network`=1 is sampled.
- SCAN latency is 1 to active_neuron cycles:
  - a hit on the first probe gives BCAST on the following edge;
  - a full miss takes active_neuron cycles.
- `networkDone` is registered: high exactly 1 cycle per iteration.
- Neurons then spend 3 cycles (RECV1/RECV2/EMIT) with `en_network`=0. WAIT therefore cannot see a stale high.
- Iteration period = WAIT + SCAN + 1 cycles.
- `run_done` asserts the cycle after the final BCAST; `busy` is low in that same cycle.

## Structure
- Shared package holds:
  - spike codes: SPK_NONE=0, SPK_POS=1, SPK_NEG=2;
  - state encoding;
  - the `{spike, id}` packing width TEN_DATA_WIDTH+NEURON_ID_WIDTH, shared with the neuron's `spike_in`.
- One sub-module, `rr_scan_ptr`: the wrapping pointer, scan counter and last-winner register, with load/step/hit inputs. The FSM stays in the top module.

## Test plan
- active=4, num_iter=1, neuron 2 spike=1, others 0 → rd_id scans 0,1,2; `spike_bcast`={1,2}; one `networkDone` pulse; `run_done` 1 cycle later; iter_count=1.
- active=4, num_iter=3, neurons 1 and 3 always spike=2 → winners in order ID1, ID3, ID1 (round-robin wraps); iter_count=3.
- No neuron spikes, active=5 → SCAN takes 5 cycles; `spike_bcast`={0,0}; `networkDone` still pulses.
- num_iter=0, start → `run_done` next cycle; `en_spike` never asserted; `busy` stays 0.
- `start` pulsed during SCAN → ignored; the run completes normally. `rd_spike`=3 at ID0 and 1 at ID1 → winner ID1.
- `reset_l` low mid-SCAN → all outputs go to reset values immediately (asynchronously). After release, a new start scans from ID 0.
